frame_draw_scheduler: RTL



---
 rtl/frame_draw_scheduler.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/frame_draw_scheduler.sv
// Purpose: per game tick, erase last frame's blocks and player, then draw this frame's blocks and player.
// Latency: first pixel is on the outputs two edges after start is accepted; one pixel per clock after that.
// Backpressure: none; start while a frame is in flight is dropped and sets the sticky frame_overrun.
module frame_draw_scheduler #(
    parameter int          NUM_BLOCKS    = 27,
    parameter int          SQ_SIZE       = 10,
    parameter int          SCREEN_W      = 160,
    parameter int          SCREEN_H      = 120,
    parameter logic [2:0]  BG_COLOUR     = 3'b000,
    parameter logic [2:0]  BLOCK_COLOUR  = 3'b111,
    parameter logic [2:0]  PLAYER_COLOUR = 3'b100
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [11*NUM_BLOCKS-1:0]  block_x_flat,
    input  logic [11*NUM_BLOCKS-1:0]  block_y_flat,
    input  logic [10:0]               move,
    input  logic [10:0]               player_x,
    input  logic [10:0]               player_y,
    output logic [7:0]                vga_x,
    output logic [6:0]                vga_y,
    output logic [2:0]                vga_colour,
    output logic                      plot,
    output logic                      busy,
    output logic                      done,
    output logic                      frame_overrun
);

    localparam int CW = (SQ_SIZE > 1) ? $clog2(SQ_SIZE) : 1;
    localparam int BW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ERASE_BLOCKS,
        ERASE_PLAYER,
        DRAW_BLOCKS,
        DRAW_PLAYER,
        DONE
    } state_t;

    state_t          state;
    state_t          state_n;

    logic [10:0]     new_move;
    logic [10:0]     new_px;
    logic [10:0]     new_py;
    logic [10:0]     old_move;
    logic [10:0]     old_px;
    logic [10:0]     old_py;
    logic            first_frame;
    // One bubble cycle after accepting start so the pixel stream starts two edges later.
    logic            settle;
    logic [BW-1:0]   blk;
    logic [CW-1:0]   dx;
    logic [CW-1:0]   dy;

    logic [10:0]     blk_x;
    logic [10:0]     blk_y;
    logic [10:0]     sq_x;
    logic [10:0]     sq_y;
    logic [2:0]      sq_colour;
    logic            visible;
    logic            drawing;
    logic            sq_end;
    logic            pass_end;
    logic [10:0]     pix_x;
    logic [10:0]     pix_y;
    logic            plot_c;
    int              blk_base;

    // Select the current square's bottom-left corner and colour, and decide whether it is on screen.
    always_comb begin
        blk_base  = 11 * int'(blk);
        blk_x     = block_x_flat[blk_base +: 11];
        blk_y     = block_y_flat[blk_base +: 11];
        sq_x      = '0;
        sq_y      = '0;
        sq_colour = BG_COLOUR;
        case (state)
            ERASE_BLOCKS: begin
                sq_x      = blk_x - old_move;
                sq_y      = blk_y;
                sq_colour = BG_COLOUR;
            end
            ERASE_PLAYER: begin
                sq_x      = old_px;
                sq_y      = old_py;
                sq_colour = BG_COLOUR;
            end
            DRAW_BLOCKS: begin
                sq_x      = blk_x - new_move;
                sq_y      = blk_y;
                sq_colour = BLOCK_COLOUR;
            end
            DRAW_PLAYER: begin
                sq_x      = new_px;
                sq_y      = new_py;
                sq_colour = PLAYER_COLOUR;
            end
            default: begin
                sq_x      = '0;
                sq_y      = '0;
                sq_colour = BG_COLOUR;
            end
        endcase

        // Unsigned compare: a square scrolled off the left edge wraps to a huge x and drops out.
        visible  = (sq_x <= 11'(SCREEN_W - SQ_SIZE)) &&
                   (sq_y >= 11'(SQ_SIZE - 1)) &&
                   (sq_y <= 11'(SCREEN_H - 1));
        drawing  = !settle && (state == ERASE_BLOCKS || state == ERASE_PLAYER ||
                               state == DRAW_BLOCKS  || state == DRAW_PLAYER);
        pix_x    = sq_x + {{(11-CW){1'b0}}, dx};
        pix_y    = sq_y - {{(11-CW){1'b0}}, dy};
        plot_c   = drawing && visible;
        sq_end   = drawing && (!visible || (dx == CW'(SQ_SIZE - 1) && dy == CW'(SQ_SIZE - 1)));
        pass_end = sq_end && (state == ERASE_PLAYER || state == DRAW_PLAYER ||
                              blk == BW'(NUM_BLOCKS - 1));
    end

    // Next-state logic: walk the four passes in order, skipping the erase passes on a first frame.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:         if (start) state_n = first_frame ? DRAW_BLOCKS : ERASE_BLOCKS;
            ERASE_BLOCKS: if (pass_end) state_n = ERASE_PLAYER;
            ERASE_PLAYER: if (pass_end) state_n = DRAW_BLOCKS;
            DRAW_BLOCKS:  if (pass_end) state_n = DRAW_PLAYER;
            DRAW_PLAYER:  if (pass_end) state_n = DONE;
            DONE:         state_n = IDLE;
            default:      state_n = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Frame latches, raster counters and the previous-frame record used by the erase passes.
    always_ff @(posedge clock) begin
        if (reset) begin
            new_move    <= '0;
            new_px      <= '0;
            new_py      <= '0;
            old_move    <= '0;
            old_px      <= '0;
            old_py      <= '0;
            first_frame <= 1'b1;
            settle      <= 1'b0;
            blk         <= '0;
            dx          <= '0;
            dy          <= '0;
        end else begin
            settle <= 1'b0;
            if (state == IDLE && start) begin
                new_move <= move;
                new_px   <= player_x;
                new_py   <= player_y;
                settle   <= 1'b1;
                blk      <= '0;
                dx       <= '0;
                dy       <= '0;
            end else if (drawing) begin
                if (sq_end) begin
                    dx  <= '0;
                    dy  <= '0;
                    blk <= pass_end ? '0 : blk + BW'(1);
                end else if (dx == CW'(SQ_SIZE - 1)) begin
                    dx <= '0;
                    dy <= dy + CW'(1);
                end else begin
                    dx <= dx + CW'(1);
                end
            end
            if (state == DONE) begin
                old_move    <= new_move;
                old_px      <= new_px;
                old_py      <= new_py;
                first_frame <= 1'b0;
            end
        end
    end

    // Registered pixel port and status; start in the DONE cycle is not treated as an overrun.
    always_ff @(posedge clock) begin
        if (reset) begin
            vga_x         <= '0;
            vga_y         <= '0;
            vga_colour    <= '0;
            plot          <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            frame_overrun <= 1'b0;
        end else begin
            vga_x      <= pix_x[7:0];
            vga_y      <= pix_y[6:0];
            vga_colour <= sq_colour;
            plot       <= plot_c;
            busy       <= (state_n != IDLE);
            done       <= (state_n == DONE);
            if (start && state != IDLE && state != DONE)
                frame_overrun <= 1'b1;
        end
    end

endmodule
